// File: rtl/imem_pkg.sv
// imem_pkg: instruction-memory geometry, NOP encoding, loader states and frame-field constants.
// Shared by the instruction memory, the fetch stage and imem_loader.
package imem_pkg;
    localparam int          MEM_WORDS      = 2048;
    localparam int          AW             = $clog2(MEM_WORDS);
    localparam logic [31:0] NOP            = 32'h0000_0013;
    localparam int          LEN_W          = 16;
    localparam int          LEN_BYTES      = LEN_W / 8;
    localparam int          BYTES_PER_WORD = 4;
    localparam int          CSUM_BYTES     = 1;
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM, ST_DONE, ST_ERR
    } ld_state_e;
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: packs accepted bytes little-endian into 32-bit words and
// flags the byte that completes a word (combinational, same cycle as that byte).
module imem_word_packer
    import imem_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);
    localparam int LW = $clog2(BYTES_PER_WORD);
    localparam int SW = 8 * (BYTES_PER_WORD - 1);
    logic [LW-1:0] lane_q, lane_d;
    logic [SW-1:0] shift_q, shift_d;
    assign lane_d      = i_clr ? '0 : i_en ? lane_q + LW'(1) : lane_q;
    assign shift_d     = i_en ? {i_byte, shift_q[SW-1:8]} : shift_q;
    assign o_word      = {i_byte, shift_q};
    assign o_word_done = i_en && lane_q == LW'(BYTES_PER_WORD - 1);
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for the instruction RAM with checksum and CPU hold.
module imem_loader
  import imem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
)
(
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_byte_valid,
  input  logic [7:0]    i_byte,
  output logic          o_byte_ready,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [31:0]   o_wdata,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic          o_cpu_hold
);
  ld_state_e        state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, len_full;
  logic [AW-1:0]    widx_q, widx_d, waddr_q, waddr_d;
  logic [7:0]       csum_q, csum_d;
  logic [31:0]      wdata_q, wdata_d, word;
  logic             we_q, word_done, last_word, accept, start_go, timeout;

  assign o_byte_ready = state_q inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM};
  assign o_busy       = o_byte_ready;
  assign o_done       = state_q == ST_DONE;
  assign o_err        = state_q == ST_ERR;
  assign o_cpu_hold   = state_q != ST_DONE;
  assign o_we         = we_q;
  assign o_waddr      = waddr_q;
  assign o_wdata      = wdata_q;
  assign accept       = i_byte_valid && o_byte_ready;
  assign start_go     = i_start && state_q inside {ST_IDLE, ST_DONE, ST_ERR};
  assign len_full     = {i_byte, len_q[7:0]};
  assign last_word    = word_done && LEN_W'(widx_q) == len_q - LEN_W'(1);

  imem_word_packer u_packer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clr       (start_go),
    .i_en        (accept && state_q == ST_DATA),
    .i_byte      (i_byte),
    .o_word      (word),
    .o_word_done (word_done)
  );

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;
  logic          timed;
  assign timed   = state_q inside {ST_LEN1, ST_DATA, ST_CSUM};
  assign to_d    = (accept || !timed) ? '0 : to_q + TW'(1);
  assign timeout = timed && !accept && to_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge i_clk) begin
    if (!i_reset) to_q <= '0;
    else          to_q <= to_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    csum_d  = csum_q;
    waddr_d = word_done ? widx_q : waddr_q;
    wdata_d = word_done ? word : wdata_q;
    if (word_done && !last_word) widx_d = widx_q + AW'(1);
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (start_go) begin
        state_d = ST_LEN0;
        len_d   = '0;
        widx_d  = '0;
        csum_d  = '0;
      end
      ST_LEN0: if (accept) begin
        len_d[7:0] = i_byte;
        state_d    = ST_LEN1;
      end
      ST_LEN1: if (accept) begin
        len_d   = len_full;
        state_d = (len_full == '0 || len_full > LEN_W'(MEM_WORDS)) ? ST_ERR : ST_DATA;
      end
      ST_DATA: if (accept) begin
        csum_d  = csum_q + i_byte;
        state_d = last_word ? ST_CSUM : ST_DATA;
      end
      ST_CSUM: if (accept) state_d = (i_byte == csum_q) ? ST_DONE : ST_ERR;
      default: state_d = ST_IDLE;
    endcase
    if (timeout) state_d = ST_ERR;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      widx_q  <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      csum_q  <= csum_d;
      we_q    <= word_done;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule
